// File: rtl/periph_bus_arbiter_pkg.sv
// rtl/periph_bus_arbiter_pkg.sv - state encoding, bus width and latency defaults for the arbiter
package periph_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RESP   = 2'd3
   } arb_state_t;

   localparam int BUS_DW     = 32;
   localparam int DEF_RD_LAT = 1;

   // Down-counter width; a zero-latency bridge still gets a 1-bit counter.
   function automatic int lat_cnt_w(input int rd_lat);
      return (rd_lat < 1) ? 1 : $clog2(rd_lat + 1);
   endfunction

endpackage

// File: rtl/periph_bus_arbiter_rr.sv
// rtl/periph_bus_arbiter_rr.sv - combinational round-robin pick: first requester after rr_last
module periph_bus_arbiter_rr #(
   parameter  int NUM_M = 2,
   localparam int IW    = $clog2(NUM_M)
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IW-1:0]    rr_last,
   output logic [NUM_M-1:0] gnt,
   output logic [IW-1:0]    idx,
   output logic             any
);

   logic [IW-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = 1; k <= NUM_M; k++) begin
         cand = IW'((int'(rr_last) + k) % NUM_M);
         if (!any && req[cand]) begin
            any       = 1'b1;
            idx       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// rtl/periph_bus_arbiter.sv - round-robin sharing of the bridge CPU port, one single-beat access per grant
module periph_bus_arbiter
   import periph_bus_arbiter_pkg::*;
#(
   parameter int NUM_M  = 2,
   parameter int RD_LAT = DEF_RD_LAT,
   parameter int DW     = BUS_DW
) (
   input  logic                clk_from_cpu,
   input  logic                rst_n_from_cpu,
   input  logic [NUM_M-1:0]    m_req,
   input  logic [NUM_M-1:0]    m_we,
   input  logic [DW*NUM_M-1:0] m_addr,
   input  logic [DW*NUM_M-1:0] m_wdata,
   output logic [NUM_M-1:0]    m_gnt,
   output logic [NUM_M-1:0]    m_rvalid,
   output logic [DW-1:0]       m_rdata,
   output logic [DW-1:0]       bus_addr,
   output logic                bus_we,
   output logic [DW-1:0]       bus_wdata,
   input  logic [DW-1:0]       bus_rdata
);

   localparam int             IW       = $clog2(NUM_M);
   localparam int             LCW      = lat_cnt_w(RD_LAT);
   localparam bit             LONG_RD  = (RD_LAT > 1);
   localparam logic [LCW-1:0] LAT_LOAD = LCW'((RD_LAT > 1) ? RD_LAT - 1 : 0);

   arb_state_t       state, state_nxt;
   logic [NUM_M-1:0] arb_gnt;
   logic [IW-1:0]    arb_idx;
   logic             arb_any;
   logic [IW-1:0]    rr_last, win_idx;
   logic             we_q, sel_we;
   logic [DW-1:0]    addr_q, wdata_q, rdata_q, sel_addr, sel_wdata;
   logic [LCW-1:0]   lat_cnt;

   periph_bus_arbiter_rr #(.NUM_M(NUM_M)) u_rr (
      .req     (m_req),
      .rr_last (rr_last),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (arb_gnt[i]) begin
            sel_we    = m_we[i];
            sel_addr  = m_addr[i*DW +: DW];
            sel_wdata = m_wdata[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk_from_cpu or negedge rst_n_from_cpu) begin
      if (!rst_n_from_cpu) state <= ST_IDLE;
      else                 state <= state_nxt;
   end

   // Request fields are frozen at arbitration so later master changes cannot leak onto the bus.
   always_ff @(posedge clk_from_cpu or negedge rst_n_from_cpu) begin
      if (!rst_n_from_cpu) begin
         win_idx <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         lat_cnt <= '0;
         rr_last <= IW'(NUM_M - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_any) begin
                  win_idx <= arb_idx;
                  rr_last <= arb_idx;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
               end
            end
            ST_ACCESS: begin
               if (!we_q) begin
                  if (LONG_RD) lat_cnt <= LAT_LOAD;
                  else         rdata_q <= bus_rdata;
               end
            end
            ST_WAIT: begin
               lat_cnt <= lat_cnt - LCW'(1);
               if (lat_cnt == LCW'(1)) rdata_q <= bus_rdata;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      m_gnt     = '0;
      m_rvalid  = '0;
      bus_addr  = '0;
      bus_we    = 1'b0;
      bus_wdata = '0;
      case (state)
         ST_IDLE: begin
            if (arb_any) state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            m_gnt[win_idx] = 1'b1;
            bus_addr       = addr_q;
            bus_wdata      = wdata_q;
            bus_we         = we_q;
            state_nxt      = (we_q || !LONG_RD) ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            bus_addr  = addr_q;
            bus_wdata = wdata_q;
            if (lat_cnt == LCW'(1)) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            m_rvalid[win_idx] = 1'b1;
            state_nxt         = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign m_rdata = rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb/tb_periph_bus_arbiter.sv - bench for periph_bus_arbiter with RD_LAT=1 and RD_LAT=3 instances
module tb_periph_bus_arbiter;

   logic        clk;
   logic        rst_n     [2];
   logic [1:0]  m_req     [2];
   logic [1:0]  m_we      [2];
   logic [63:0] m_addr    [2];
   logic [63:0] m_wdata   [2];
   logic [1:0]  m_gnt     [2];
   logic [1:0]  m_rvalid  [2];
   logic [31:0] m_rdata   [2];
   logic [31:0] bus_addr  [2];
   logic        bus_we    [2];
   logic [31:0] bus_wdata [2];
   logic [31:0] bus_rdata [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Transaction-level reference: one outstanding record per instance.
   int          lat_of    [2] = '{1, 3};
   bit          txn_on    [2];
   int          ts        [2];
   int          tw_len    [2];
   bit          tw        [2];
   bit          twe       [2];
   logic [31:0] taddr     [2];
   logic [31:0] twdata    [2];
   int          next_idle [2];
   bit          rr_last   [2];
   logic [31:0] last_rd   [2];
   bit          pend      [2][2];

   typedef struct {
      bit          d;
      bit          m;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
   } vec_t;
   vec_t vecs [6];

   function automatic logic [31:0] bridge(input logic [31:0] a, input int c);
      if (a[31:28] == 4'h8) return 32'hdeadbfee;
      if (a == 32'h0000_0010) return 32'h1234_5678;
      return a ^ 32'h5A5A_0F0F ^ 32'(c);
   endfunction

   assign bus_rdata[0] = bridge(bus_addr[0], cyc);
   assign bus_rdata[1] = bridge(bus_addr[1], cyc);

   periph_bus_arbiter #(.NUM_M(2), .RD_LAT(1), .DW(32)) u_dut_l1 (
      .clk_from_cpu   (clk),
      .rst_n_from_cpu (rst_n[0]),
      .m_req          (m_req[0]),
      .m_we           (m_we[0]),
      .m_addr         (m_addr[0]),
      .m_wdata        (m_wdata[0]),
      .m_gnt          (m_gnt[0]),
      .m_rvalid       (m_rvalid[0]),
      .m_rdata        (m_rdata[0]),
      .bus_addr       (bus_addr[0]),
      .bus_we         (bus_we[0]),
      .bus_wdata      (bus_wdata[0]),
      .bus_rdata      (bus_rdata[0])
   );

   periph_bus_arbiter #(.NUM_M(2), .RD_LAT(3), .DW(32)) u_dut_l3 (
      .clk_from_cpu   (clk),
      .rst_n_from_cpu (rst_n[1]),
      .m_req          (m_req[1]),
      .m_we           (m_we[1]),
      .m_addr         (m_addr[1]),
      .m_wdata        (m_wdata[1]),
      .m_gnt          (m_gnt[1]),
      .m_rvalid       (m_rvalid[1]),
      .m_rdata        (m_rdata[1]),
      .bus_addr       (bus_addr[1]),
      .bus_we         (bus_we[1]),
      .bus_wdata      (bus_wdata[1]),
      .bus_rdata      (bus_rdata[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, got, want, cyc);
      end
   endtask

   task automatic set_m(input bit d, input bit k, input bit req, input bit we,
                        input logic [31:0] a, input logic [31:0] w);
      m_req[d][k] = req;
      m_we[d][k]  = we;
      if (k) begin
         m_addr[d][63:32]  = a;
         m_wdata[d][63:32] = w;
      end else begin
         m_addr[d][31:0]  = a;
         m_wdata[d][31:0] = w;
      end
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] r;
      r = $urandom();
      case ($urandom_range(3))
         0:       r[31:28] = 4'h8;
         1:       r = 32'h0000_0010;
         default: if (r[31:28] == 4'h8) r[31:28] = 4'h1;
      endcase
      return r;
   endfunction

   task automatic model_reset(input bit d);
      txn_on[d]    = 1'b0;
      next_idle[d] = 0;
      rr_last[d]   = 1'b1;
      last_rd[d]   = '0;
   endtask

   // Called with the inputs that the DUT samples at the end of cycle cyc.
   task automatic model_step(input bit d);
      int w;
      bit cb;
      if (!rst_n[d]) return;
      if (cyc >= next_idle[d] && m_req[d] != 2'b00) begin
         w = -1;
         for (int k = 1; k <= 2; k++) begin
            cb = 1'((int'(rr_last[d]) + k) % 2);
            if (w < 0 && m_req[d][cb]) w = int'(cb);
         end
         cb           = 1'(w);
         txn_on[d]    = 1'b1;
         ts[d]        = cyc;
         tw[d]        = cb;
         twe[d]       = m_we[d][cb];
         taddr[d]     = cb ? m_addr[d][63:32]  : m_addr[d][31:0];
         twdata[d]    = cb ? m_wdata[d][63:32] : m_wdata[d][31:0];
         tw_len[d]    = twe[d] ? 0 : ((lat_of[d] > 1) ? lat_of[d] - 1 : 0);
         next_idle[d] = cyc + 3 + tw_len[d];
         rr_last[d]   = cb;
      end
   endtask

   task automatic check(input bit d);
      logic [1:0]  eg, ev;
      logic        ew;
      logic [31:0] ea, ewd, er;
      int          m;
      m = cyc; eg = '0; ev = '0; ew = 1'b0; ea = '0; ewd = '0; er = m_rdata[d];
      if (txn_on[d]) begin
         if (m == ts[d] + 1) begin
            eg = 2'b01 << tw[d];
            ew = twe[d];
         end
         if (m >= ts[d] + 1 && m <= ts[d] + 1 + tw_len[d]) begin
            ea  = taddr[d];
            ewd = twdata[d];
         end
         if (m == ts[d] + 2 + tw_len[d]) begin
            ev = 2'b01 << tw[d];
            er = twe[d] ? last_rd[d] : bridge(taddr[d], ts[d] + 1 + tw_len[d]);
            last_rd[d] = er;
         end
      end
      n_tests++;
      if (m_gnt[d] !== eg || m_rvalid[d] !== ev || bus_we[d] !== ew || bus_addr[d] !== ea ||
          bus_wdata[d] !== ewd || (ev != 2'b00 && m_rdata[d] !== er)) begin
         n_fail++;
         $display("FAIL cycle_check dut%0d cyc %0d: got gnt=%b rv=%b we=%b addr=%h wd=%h rd=%h, expected gnt=%b rv=%b we=%b addr=%h wd=%h rd=%h",
                  d, cyc, m_gnt[d], m_rvalid[d], bus_we[d], bus_addr[d], bus_wdata[d], m_rdata[d],
                  eg, ev, ew, ea, ewd, er);
      end
   endtask

   task automatic tick();
      model_step(1'b0);
      model_step(1'b1);
      @(negedge clk);
      cyc++;
      check(1'b0);
      check(1'b1);
   endtask

   task automatic chk_zero(input bit d);
      chk("rst_gnt_rv_we", 32'({m_gnt[d], m_rvalid[d], bus_we[d]}), 32'd0);
      chk("rst_bus_addr",  bus_addr[d],  32'd0);
      chk("rst_bus_wdata", bus_wdata[d], 32'd0);
      chk("rst_m_rdata",   m_rdata[d],   32'd0);
   endtask

   task automatic do_reset(input bit d);
      #2;
      rst_n[d] = 1'b0;
      model_reset(d);
      #1;
      chk_zero(d);
      tick();
      tick();
      rst_n[d] = 1'b1;
   endtask

   task automatic idle_all(input int n);
      for (bit d = 0; ; d++) begin
         set_m(d, 1'b0, 1'b0, 1'b0, '0, '0);
         set_m(d, 1'b1, 1'b0, 1'b0, '0, '0);
         if (d) break;
      end
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_vec(input vec_t v);
      int t0, gc, rc;
      logic [1:0]  g, rv;
      logic        gwe;
      logic [31:0] gwd, rd;
      idle_all(6);
      set_m(v.d, v.m, 1'b1, v.we, v.addr, v.wdata);
      t0 = cyc; gc = -1; rc = -1; g = '0; rv = '0; gwe = 1'b0; gwd = '0; rd = '0;
      for (int i = 0; i < 12 && rc < 0; i++) begin
         tick();
         if (gc < 0 && m_gnt[v.d] != 2'b00) begin
            gc = cyc; g = m_gnt[v.d]; gwe = bus_we[v.d]; gwd = bus_wdata[v.d];
            set_m(v.d, v.m, 1'b0, 1'b0, '0, '0);
         end
         if (rc < 0 && m_rvalid[v.d] != 2'b00) begin
            rc = cyc; rv = m_rvalid[v.d]; rd = m_rdata[v.d];
         end
      end
      chk("vec_gnt_latency",    32'(gc - t0), 32'd1);
      chk("vec_gnt_onehot",     32'(g), 32'(2'b01 << v.m));
      chk("vec_bus_we",         32'(gwe), 32'(v.we));
      chk("vec_bus_wdata",      gwd, v.wdata);
      chk("vec_rvalid_latency", 32'(rc - t0), 32'(v.lat));
      chk("vec_rvalid_onehot",  32'(rv), 32'(2'b01 << v.m));
      if (!v.we) chk("vec_rdata", rd, v.rdata);
   endtask

   task automatic drive_rand(input bit d);
      bit kb;
      for (int k = 0; k < 2; k++) begin
         kb = k[0];
         if (pend[d][kb] && m_gnt[d][kb]) pend[d][kb] = 1'b0;
         if (pend[d][kb]) begin
            if ($urandom_range(99) < 4) begin
               pend[d][kb] = 1'b0;
               set_m(d, kb, 1'b0, 1'($urandom_range(1)), rand_addr(), $urandom());
            end
         end else if ($urandom_range(99) < 35) begin
            pend[d][kb] = 1'b1;
            set_m(d, kb, 1'b1, 1'($urandom_range(1)), rand_addr(), $urandom());
         end else begin
            set_m(d, kb, 1'b0, 1'($urandom_range(1)), rand_addr(), $urandom());
         end
      end
   endtask

   initial begin
      logic [1:0] order [4];
      int         ng;
      bit         found, rv_seen;

      vecs[0] = '{d:1'b0, m:1'b0, we:1'b1, addr:32'hFFFF_F060, wdata:32'h0000_00A5, lat:2, rdata:32'h0};
      vecs[1] = '{d:1'b0, m:1'b1, we:1'b0, addr:32'h0000_0010, wdata:32'h0,         lat:2, rdata:32'h1234_5678};
      vecs[2] = '{d:1'b1, m:1'b0, we:1'b0, addr:32'h0000_0010, wdata:32'h0,         lat:4, rdata:32'h1234_5678};
      vecs[3] = '{d:1'b1, m:1'b1, we:1'b1, addr:32'h0000_0400, wdata:32'hCAFE_0001, lat:2, rdata:32'h0};
      vecs[4] = '{d:1'b0, m:1'b1, we:1'b0, addr:32'h8000_0004, wdata:32'h0,         lat:2, rdata:32'hdeadbfee};
      vecs[5] = '{d:1'b1, m:1'b1, we:1'b0, addr:32'h8765_4320, wdata:32'h0,         lat:4, rdata:32'hdeadbfee};

      rst_n[0] = 1'b0; rst_n[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         m_req[d] = '0; m_we[d] = '0; m_addr[d] = '0; m_wdata[d] = '0;
         model_reset(1'(d));
         pend[d][0] = 1'b0; pend[d][1] = 1'b0;
      end
      tick();
      tick();
      chk_zero(1'b0);
      chk_zero(1'b1);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Both masters requesting continuously must alternate, starting at M0 after reset.
      idle_all(6);
      do_reset(1'b0);
      set_m(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_F000, 32'h0000_0111);
      set_m(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
      ng = 0;
      for (int i = 0; i < 40 && ng < 4; i++) begin
         tick();
         if (m_gnt[0] != 2'b00) begin
            order[ng] = m_gnt[0];
            ng++;
         end
      end
      chk("rr_grants_seen", 32'(ng), 32'd4);
      for (int i = 0; i < 4 && i < ng; i++)
         chk("rr_order", 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd2);

      // Reset while a long read sits in WAIT.
      idle_all(6);
      set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick();
         if (m_gnt[1] != 2'b00) begin
            found = 1'b1;
            set_m(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
         end
      end
      chk("wait_rst_gnt_seen", 32'(found), 32'd1);
      tick();
      chk("wait_rst_bus_addr_before", bus_addr[1], 32'h0000_0020);
      do_reset(1'b1);
      rv_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (m_rvalid[1] != 2'b00) rv_seen = 1'b1;
      end
      chk("wait_rst_no_rvalid", 32'(rv_seen), 32'd0);
      set_m(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
      set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick();
         if (m_gnt[1] != 2'b00) begin
            found = 1'b1;
            chk("post_rst_first_gnt", 32'(m_gnt[1]), 32'd1);
         end
      end
      chk("post_rst_gnt_seen", 32'(found), 32'd1);

      // Master fields changed right after grant must not reach the bus.
      idle_all(8);
      set_m(1'b1, 1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0000_0000);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick();
         if (m_gnt[1] != 2'b00) found = 1'b1;
      end
      chk("latch_gnt_seen", 32'(found), 32'd1);
      set_m(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF);
      tick();
      chk("latch_bus_addr",  bus_addr[1],  32'h8000_0100);
      chk("latch_bus_wdata", bus_wdata[1], 32'h0000_0000);
      chk("latch_bus_we",    32'(bus_we[1]), 32'd0);
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         tick();
         if (m_rvalid[1] != 2'b00) begin
            found = 1'b1;
            chk("latch_rvalid", 32'(m_rvalid[1]), 32'd2);
            chk("unmapped_rdata", m_rdata[1], 32'hdeadbfee);
         end
      end
      chk("latch_rvalid_seen", 32'(found), 32'd1);

      idle_all(6);
      for (int i = 0; i < 1500; i++) begin
         drive_rand(1'b0);
         drive_rand(1'b1);
         tick();
      end
      idle_all(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
